// File: rtl/uniop_ctrl.sv
// Multi-cycle control unit for the accumulator processor: fetch, decode,
// operand read, ALU sequencing and data-memory stores.
module uniop_ctrl #(
  parameter int unsigned AW      = 12,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] imem_addr,
  input  logic [15:0]   imem_rdata,
  output logic [AW-1:0] dmem_addr,
  output logic          dmem_rd,
  input  logic [15:0]   dmem_rdata,
  output logic          dmem_wr,
  output logic [15:0]   dmem_wdata,
  output logic [2:0]    alu_sel,
  output logic [15:0]   alu_a,
  output logic [15:0]   alu_b,
  input  logic [15:0]   alu_out,
  input  logic          alu_zf,
  output logic [15:0]   acc,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          illegal
);

  localparam int unsigned CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ALU_LAT);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_LDI = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMRD, S_LOAD, S_EXEC, S_STORE, S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [15:0]     acc_q, acc_d;
  logic [15:0]     opnd_q, opnd_d;
  logic [15:0]     ir_q, ir_d;
  logic            zflag_q, zflag_d;
  logic            illegal_q, illegal_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ready_q;
  logic            dmem_rd_q, dmem_wr_q;
  logic [2:0]      alu_sel_q, alu_sel_d;
  logic            busy_q, halted_q;

  logic [3:0]      op_c;
  logic [AW-1:0]   tgt_c;

  function automatic logic [2:0] alu_fn(input logic [3:0] op);
    case (op)
      OP_SUB:  alu_fn = 3'd1;
      OP_AND:  alu_fn = 3'd2;
      OP_OR:   alu_fn = 3'd3;
      OP_XOR:  alu_fn = 3'd4;
      OP_NOT:  alu_fn = 3'd5;
      default: alu_fn = 3'd0;
    endcase
  endfunction

  // In DECODE the instruction is still on the bus; afterwards it lives in ir.
  assign op_c  = (state_q == S_DECODE) ? imem_rdata[15:12] : ir_q[15:12];
  assign tgt_c = AW'(imem_rdata[11:0]);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    ir_d      = ir_q;
    zflag_d   = zflag_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start && ready_q) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          illegal_d = 1'b0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = imem_rdata;
        pc_d = pc_q + AW'(1);
        case (op_c)
          OP_NOP: state_d = S_FETCH;
          OP_JMP: begin
            state_d = S_FETCH;
            pc_d    = tgt_c;
          end
          OP_JZ: begin
            state_d = S_FETCH;
            if (zflag_q) pc_d = tgt_c;
          end
          OP_LDI: begin
            state_d = S_FETCH;
            acc_d   = {4'h0, imem_rdata[11:0]};
            zflag_d = (imem_rdata[11:0] == 12'h000);
          end
          OP_STA: state_d = S_STORE;
          OP_NOT: begin
            state_d = S_EXEC;
            cnt_d   = '0;
          end
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = S_MEMRD;
          OP_HLT: state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMRD: state_d = S_LOAD;
      S_LOAD: begin
        opnd_d = dmem_rdata;
        if (op_c == OP_LDA) begin
          acc_d   = dmem_rdata;
          zflag_d = (dmem_rdata == 16'h0000);
          state_d = S_FETCH;
        end else begin
          cnt_d   = '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == LAST_CNT) begin
          acc_d   = alu_out;
          zflag_d = alu_zf;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STORE: state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
    alu_sel_d = (state_d == S_EXEC) ? alu_fn(op_c) : 3'd0;
  end

  // ready_q masks a start that coincides with reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      ir_q      <= '0;
      zflag_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      dmem_rd_q <= 1'b0;
      dmem_wr_q <= 1'b0;
      alu_sel_q <= 3'd0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      ir_q      <= ir_d;
      zflag_q   <= zflag_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      ready_q   <= 1'b1;
      dmem_rd_q <= (state_d == S_MEMRD);
      dmem_wr_q <= (state_d == S_STORE);
      alu_sel_q <= alu_sel_d;
      busy_q    <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q  <= (state_d == S_HALT);
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = AW'(ir_q[11:0]);
  assign dmem_rd    = dmem_rd_q;
  assign dmem_wr    = dmem_wr_q;
  assign dmem_wdata = acc_q;
  assign alu_sel    = alu_sel_q;
  assign alu_a      = acc_q;
  assign alu_b      = opnd_q;
  assign acc        = acc_q;
  assign pc         = pc_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_uniop_ctrl.sv
// Bench for uniop_ctrl: instruction-level model expands each instruction into
// its expected per-cycle outputs; a negedge process compares them to the DUT.
module tb_uniop_ctrl;

  localparam int unsigned LAT1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 1: AW=12, ALU_LAT=1
  logic        rst1, start1;
  logic [11:0] imem_addr1, dmem_addr1, pc1;
  logic [15:0] imem_rdata1, dmem_rdata1, dmem_wdata1, alu_a1, alu_b1, alu_out1, acc1;
  logic        dmem_rd1, dmem_wr1, alu_zf1, busy1, halted1, illegal1;
  logic [2:0]  alu_sel1;

  // DUT 2: AW=4, ALU_LAT=0
  logic        rst2, start2;
  logic [3:0]  imem_addr2, dmem_addr2, pc2;
  logic [15:0] imem_rdata2, dmem_rdata2, dmem_wdata2, alu_a2, alu_b2, alu_out2, acc2;
  logic        dmem_rd2, dmem_wr2, alu_zf2, busy2, halted2, illegal2;
  logic [2:0]  alu_sel2;

  uniop_ctrl #(.AW(12), .ALU_LAT(LAT1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1),
    .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
    .dmem_addr(dmem_addr1), .dmem_rd(dmem_rd1), .dmem_rdata(dmem_rdata1),
    .dmem_wr(dmem_wr1), .dmem_wdata(dmem_wdata1),
    .alu_sel(alu_sel1), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_out(alu_out1), .alu_zf(alu_zf1),
    .acc(acc1), .pc(pc1), .busy(busy1), .halted(halted1), .illegal(illegal1));

  uniop_ctrl #(.AW(4), .ALU_LAT(0)) dut2 (
    .clk(clk), .rst(rst2), .start(start2),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .dmem_addr(dmem_addr2), .dmem_rd(dmem_rd2), .dmem_rdata(dmem_rdata2),
    .dmem_wr(dmem_wr2), .dmem_wdata(dmem_wdata2),
    .alu_sel(alu_sel2), .alu_a(alu_a2), .alu_b(alu_b2),
    .alu_out(alu_out2), .alu_zf(alu_zf2),
    .acc(acc2), .pc(pc2), .busy(busy2), .halted(halted2), .illegal(illegal2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- environment: ALUs and memories ----------------
  function automatic logic [15:0] alu_f(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    case (s)
      3'd0: alu_f = a + b;
      3'd1: alu_f = a - b;
      3'd2: alu_f = a & b;
      3'd3: alu_f = a | b;
      3'd4: alu_f = a ^ b;
      3'd5: alu_f = ~a;
      default: alu_f = 16'h0;
    endcase
  endfunction

  function automatic logic [15:0] dflt(input logic [11:0] a);
    logic [15:0] t;
    t = {4'h0, a} * 16'h9E37;
    return t ^ 16'h5A5A;
  endfunction

  always_ff @(posedge clk) alu_out1 <= alu_f(alu_sel1, alu_a1, alu_b1);
  assign alu_zf1     = (alu_out1 == 16'h0);
  assign alu_out2    = alu_f(alu_sel2, alu_a2, alu_b2);
  assign alu_zf2     = (alu_out2 == 16'h0);
  assign dmem_rdata2 = 16'h0;

  logic [15:0] imem1 [4096];
  logic [15:0] imem2 [16];
  always_ff @(posedge clk) imem_rdata1 <= imem1[imem_addr1];
  always_ff @(posedge clk) imem_rdata2 <= imem2[imem_addr2];

  logic [15:0] dmem1 [4096];
  bit          dval1 [4096];
  logic        tb_we;
  logic [11:0] tb_wa;
  logic [15:0] tb_wd;
  always_ff @(posedge clk) begin
    if (tb_we) begin
      dmem1[tb_wa] <= tb_wd;
      dval1[tb_wa] <= 1'b1;
    end else if (dmem_wr1) begin
      dmem1[dmem_addr1] <= dmem_wdata1;
      dval1[dmem_addr1] <= 1'b1;
    end
    dmem_rdata1 <= dval1[dmem_addr1] ? dmem1[dmem_addr1] : dflt(dmem_addr1);
  end

  // ---------------- instruction-level model ----------------
  typedef struct {
    logic [11:0] pc;
    logic [15:0] acc;
    logic        hlt, ill, rd, wr, ex, chkb;
    logic [11:0] addr;
    logic [2:0]  sel;
    logic [15:0] b;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_acc;
  logic        m_zf, m_ill;
  logic [15:0] mdm [4096];
  bit          mval [4096];

  function automatic logic [15:0] mrd(input logic [11:0] a);
    return mval[a] ? mdm[a] : dflt(a);
  endfunction

  task automatic push(input logic [11:0] p, input logic [15:0] a, input logic hlt,
                      input logic rd, input logic wr, input logic ex, input logic chkb,
                      input logic [11:0] ad, input logic [2:0] sel, input logic [15:0] b);
    exp_t e;
    e.pc = p; e.acc = a; e.hlt = hlt; e.ill = m_ill; e.rd = rd; e.wr = wr;
    e.ex = ex; e.chkb = chkb; e.addr = ad; e.sel = sel; e.b = b;
    exp_q.push_back(e);
  endtask

  // Each instruction: FETCH+DECODE cycles at the old pc, then its extra cycles.
  task automatic model_run();
    logic [11:0] p, pn, opa;
    logic [15:0] ins, m;
    logic [3:0]  op;
    p = 12'h0;
    m_ill = 1'b0;
    for (int n = 0; n < 500; n++) begin
      ins = imem1[p]; op = ins[15:12]; opa = ins[11:0]; pn = p + 12'd1;
      push(p, m_acc, 0, 0, 0, 0, 0, 0, 0, 0);
      push(p, m_acc, 0, 0, 0, 0, 0, 0, 0, 0);
      if (op == 4'h0) p = pn;
      else if (op == 4'h9) p = opa;
      else if (op == 4'hA) p = m_zf ? opa : pn;
      else if (op == 4'hB) begin
        m_acc = {4'h0, opa}; m_zf = (opa == 12'h0); p = pn;
      end else if (op == 4'h2) begin
        push(pn, m_acc, 0, 0, 1, 0, 0, opa, 0, 0);
        mdm[opa] = m_acc; mval[opa] = 1'b1; p = pn;
      end else if (op == 4'h1) begin
        m = mrd(opa);
        push(pn, m_acc, 0, 1, 0, 0, 0, opa, 0, 0);
        push(pn, m_acc, 0, 0, 0, 0, 0, 0, 0, 0);
        m_acc = m; m_zf = (m == 16'h0); p = pn;
      end else if (op >= 4'h3 && op <= 4'h7) begin
        m = mrd(opa);
        push(pn, m_acc, 0, 1, 0, 0, 0, opa, 0, 0);
        push(pn, m_acc, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k <= int'(LAT1); k++)
          push(pn, m_acc, 0, 0, 0, 1, 1, 0, 3'(op - 4'h3), m);
        case (op)
          4'h3:    m_acc = m_acc + m;
          4'h4:    m_acc = m_acc - m;
          4'h5:    m_acc = m_acc & m;
          4'h6:    m_acc = m_acc | m;
          default: m_acc = m_acc ^ m;
        endcase
        m_zf = (m_acc == 16'h0); p = pn;
      end else if (op == 4'h8) begin
        for (int k = 0; k <= int'(LAT1); k++)
          push(pn, m_acc, 0, 0, 0, 1, 0, 0, 3'd5, 0);
        m_acc = ~m_acc; m_zf = (m_acc == 16'h0); p = pn;
      end else begin
        m_ill = (op != 4'hF);
        repeat (3) push(pn, m_acc, 1, 0, 0, 0, 0, 0, 0, 0);
        break;
      end
    end
  endtask

  // Per-cycle comparison of DUT 1 against the expanded model trace.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("pc", pc1, e.pc);
      chk("imem_addr", imem_addr1, e.pc);
      chk("acc", acc1, e.acc);
      chk("busy", busy1, !e.hlt);
      chk("halted", halted1, e.hlt);
      chk("illegal", illegal1, e.ill);
      chk("dmem_rd", dmem_rd1, e.rd);
      chk("dmem_wr", dmem_wr1, e.wr);
      chk("alu_sel", alu_sel1, e.ex ? e.sel : 3'd0);
      if (e.rd || e.wr) chk("dmem_addr", dmem_addr1, e.addr);
      if (e.wr) chk("dmem_wdata", dmem_wdata1, e.acc);
      if (e.ex) chk("alu_a", alu_a1, e.acc);
      if (e.chkb) chk("alu_b", alu_b1, e.b);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic dwr(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk); tb_wa = a; tb_wd = d; tb_we = 1'b1;
    @(negedge clk); tb_we = 1'b0;
    mdm[a] = d; mval[a] = 1'b1;
  endtask

  task automatic load_prog(input logic [15:0] pr [$]);
    for (int i = 0; i < 64; i++) imem1[i] = 16'hF000;
    foreach (pr[i]) imem1[i] = pr[i];
  endtask

  task automatic run1(output int cyc);
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    model_run();
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy1) cyc++;
      if (halted1) break;
    end
    chk("halt_reached", halted1, 1'b1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("trace_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          cyc, len, found;
    logic [15:0] prog[$];
    logic [3:0]  op;
    logic [11:0] opr;
    rst1 = 1'b0; rst2 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    m_acc = 16'h0; m_zf = 1'b0; m_ill = 1'b0;
    for (int i = 0; i < 4096; i++) imem1[i] = 16'hF000;
    for (int i = 0; i < 16; i++) imem2[i] = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc1, 0);     chk("rst_acc", acc1, 0);
    chk("rst_busy", busy1, 0); chk("rst_halted", halted1, 0);
    chk("rst_illegal", illegal1, 0);
    chk("rst_strobes", {dmem_rd1, dmem_wr1}, 0); chk("rst_alu_sel", alu_sel1, 0);
    rst1 = 1'b1; rst2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy1, 0); chk("idle_halted", halted1, 0);

    // LDI 5; ADD [0x10]; STA [0x11]; HLT
    dwr(12'h010, 16'd3);
    prog = {16'hB005, 16'h3010, 16'h2011, 16'hF000};
    load_prog(prog); run1(cyc);
    chk("A_cycles", cyc, 13);       chk("A_store", dmem1[12'h011], 16'd8);
    chk("A_acc", acc1, 16'd8);      chk("A_halted", halted1, 1);
    chk("A_pc", pc1, 4);

    // LDA [0x20]; SUB [0x21]; JZ 8; HLT; ... 8: LDI 0xABC
    dwr(12'h020, 16'd7); dwr(12'h021, 16'd7);
    prog = {16'h1020, 16'h4021, 16'hA008, 16'hF000};
    load_prog(prog); imem1[8] = 16'hBABC;
    run1(cyc);
    chk("B_taken_acc", acc1, 16'h0ABC); chk("B_taken_pc", pc1, 10);
    dwr(12'h021, 16'd6);
    run1(cyc);
    chk("B_fall_acc", acc1, 16'd1); chk("B_fall_pc", pc1, 4);

    // LDI 0; NOT; HLT
    prog = {16'hB000, 16'h8000, 16'hF000};
    load_prog(prog); run1(cyc);
    chk("not_acc", acc1, 16'hFFFF); chk("not_cycles", cyc, 8);

    // illegal opcode at pc 2, then restart clears it
    prog = {16'h0000, 16'h0000, 16'hC000};
    load_prog(prog); run1(cyc);
    chk("ill_flag", illegal1, 1); chk("ill_halted", halted1, 1); chk("ill_pc", pc1, 3);
    prog = {16'hB001, 16'hF000};
    load_prog(prog); run1(cyc);
    chk("ill_cleared", illegal1, 0); chk("ill_restart_pc", pc1, 2); chk("ill_restart_acc", acc1, 1);

    // random forward-only programs
    for (int r = 0; r < 25; r++) begin
      repeat (3) dwr(12'($urandom_range(0, 31)),
                     ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
      len = int'($urandom_range(6, 20));
      prog = {};
      for (int i = 0; i < len - 1; i++) begin
        op = 4'($urandom_range(0, 15));
        if (op >= 4'hC && op <= 4'hE && $urandom_range(0, 3) != 0) op = 4'h3;
        if (op == 4'h9 || op == 4'hA) opr = 12'($urandom_range(i + 1, len - 1));
        else if (op == 4'hB) opr = ($urandom_range(0, 3) == 0) ? 12'h0 : 12'($urandom);
        else if ($urandom_range(0, 1) == 0) opr = 12'($urandom_range(0, 31));
        else opr = 12'($urandom_range(4064, 4095));
        prog.push_back({op, opr});
      end
      prog.push_back(16'hF000);
      load_prog(prog); run1(cyc);
    end

    // reset mid-EXEC: LDI 5; SUB [0x10]; HLT
    prog = {16'hB005, 16'h4010, 16'hF000};
    load_prog(prog);
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    model_run();
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (alu_sel1 == 3'd1) begin found = 1; break; end
    end
    chk("exec_seen", found, 1);
    @(posedge clk); #2 rst1 = 1'b0;
    exp_q.delete(); m_acc = 16'h0; m_zf = 1'b0; m_ill = 1'b0;
    #1;
    chk("mid_rst_pc", pc1, 0);     chk("mid_rst_acc", acc1, 0);
    chk("mid_rst_busy", busy1, 0); chk("mid_rst_halted", halted1, 0);
    chk("mid_rst_illegal", illegal1, 0);
    chk("mid_rst_strobes", {dmem_rd1, dmem_wr1}, 0); chk("mid_rst_alu_sel", alu_sel1, 0);
    start1 = 1'b1;
    @(negedge clk); rst1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    chk("rel_start_ignored", busy1, 0);
    repeat (3) @(negedge clk);
    chk("stay_idle_busy", busy1, 0); chk("stay_idle_halted", halted1, 0);

    // DUT 2: NOP loop, start while busy, pc wrap
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (pc2 == 4'd3) break; end
    chk("d2_pc3", pc2, 3);
    start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    repeat (4) @(negedge clk);
    chk("d2_busy_start_ignored", pc2, 5); chk("d2_busy", busy2, 1);
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (pc2 == 4'd15) break; end
    chk("d2_pc15", pc2, 15);
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (pc2 != 4'd15) break; end
    chk("d2_pc_wrap", pc2, 0);
    chk("d2_no_mem", {dmem_rd2, dmem_wr2}, 0);
    rst2 = 1'b0; @(negedge clk); rst2 = 1'b1;
    repeat (2) @(negedge clk);

    // DUT 2: LDI 0; NOT; HLT with a combinational ALU
    imem2[0] = 16'hB000; imem2[1] = 16'h8000; imem2[2] = 16'hF000;
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy2) cyc++;
      if (halted2) break;
    end
    chk("d2_halted", halted2, 1); chk("d2_cycles", cyc, 7);
    chk("d2_acc", acc2, 16'hFFFF); chk("d2_pc", pc2, 3);
    chk("d2_illegal", illegal2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uniop_ctrl.md
Name: uniop_ctrl

Overview:
Multi-cycle control unit for the uni-operand (accumulator) processor. It fetches 16-bit instructions, decodes them, reads the operand from data memory and sequences the 16-bit ALU (sel/in1/in2/out/zf). It holds the accumulator, PC and zero flag, and drives data-memory writes. It sits between the instruction/data memories and the ALU, and is the only master of both.

Parameters:
AW, 12, instruction and data address width; PC wraps modulo 2^AW.
ALU_LAT, 1, ALU result latency in cycles after sel/operands become stable (0 = combinational).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; begins execution at PC=0 from IDLE or HALT
imem_addr  out  AW  instruction address (= pc)
imem_rdata  in  16  instruction; valid the cycle after imem_addr is presented
dmem_addr  out  AW  data address (= ir[AW-1:0])
dmem_rd  out  1  data read strobe; dmem_rdata valid the next cycle
dmem_rdata  in  16  data read value
dmem_wr  out  1  data write strobe, 1 cycle
dmem_wdata  out  16  write data (= acc)
alu_sel  out  3  ALU function select
alu_a  out  16  ALU in1 (= acc)
alu_b  out  16  ALU in2 (= opnd register)
alu_out  in  16  ALU result
alu_zf  in  1  ALU zero flag
acc  out  16  accumulator
pc  out  AW  program counter
busy  out  1  high in any state except IDLE/HALT
halted  out  1  high in HALT
illegal  out  1  sticky; set on undefined opcode, cleared by start/reset

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=0, acc=0, opnd=0, ir=0, zflag=0, illegal=0, all strobes 0, alu_sel=0, busy=0, halted=0.
- Opcode = ir[15:12]; operand = ir[11:0], truncated/zero-extended to AW.
- Opcodes: 0 NOP; 1 LDA acc<=M; 2 STA M<=acc; 3 ADD; 4 SUB (acc-M); 5 AND; 6 OR; 7 XOR; 8 NOT (acc<=~acc, no memory read); 9 JMP; A JZ (jump if zflag); B LDI (acc<=zero-extended ir[11:0]); F HLT; C/D/E illegal.
- alu_sel encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5; alu_sel=0 outside EXEC.
- States: IDLE, FETCH, DECODE, MEMRD, LOAD, EXEC, STORE, HALT.
- IDLE/HALT --start--> FETCH with pc=0 and illegal=0. start is ignored while busy.
- FETCH: imem_addr=pc. Next: DECODE.
- DECODE: ir<=imem_rdata, pc<=pc+1 (wraps). Branch on opcode:
  - NOP -> FETCH.
  - JMP -> FETCH with pc<=operand.
  - JZ -> FETCH with pc<=operand if zflag=1, else pc+1.
  - LDI -> FETCH with acc<=imm, zflag<=(imm==0).
  - STA -> STORE.
  - NOT -> EXEC.
  - LDA/ADD..XOR -> MEMRD.
  - HLT -> HALT.
  - Illegal -> HALT with illegal<=1.
- MEMRD: dmem_rd=1. Next: LOAD.
- LOAD: opnd<=dmem_rdata. For LDA, acc<=dmem_rdata, zflag<=(dmem_rdata==0), then FETCH. Otherwise EXEC.
- EXEC: alu_sel/alu_a/alu_b held stable for ALU_LAT+1 cycles (internal counter). On the last cycle, acc<=alu_out and zflag<=alu_zf. Next: FETCH.
- STORE: dmem_wr=1 for exactly 1 cycle, dmem_addr=operand, dmem_wdata=acc. zflag unchanged. Next: FETCH.
- Cycle counts from FETCH entry to next FETCH:
  - NOP/JMP/JZ/LDI: 2.
  - STA: 3.
  - LDA: 4.
  - NOT: 3+ALU_LAT.
  - ADD..XOR: 5+ALU_LAT.
- ALU arithmetic wraps mod 2^16. The carry is not kept. zflag is taken only from alu_zf for ALU ops.
- PC wraps 2^AW-1 -> 0 with no fault.
- dmem_rd and dmem_wr are never high in the same cycle.
- Reset asserted mid-operation aborts immediately to the reset values. A STORE in flight is dropped.
- start and reset deasserting in the same cycle: start is ignored.

Test Plan:
- Reset with rst=0 mid-EXEC -> all outputs at reset values asynchronously. After release, state stays IDLE until start.
- Program LDI 5; ADD [0x10] (M=3); STA [0x11]; HLT; start -> dmem write addr 0x11 data 8, acc=8, zflag=0, halted=1. ADD takes 6 cycles with ALU_LAT=1.
- Program LDA [0x20]=7; SUB [0x21]=7; JZ 0x008; HLT at 0x003; LDI 0xABC at 0x008 -> jump taken, acc=0x0ABC. Repeat with M[0x21]=6 -> halts at 0x003 with acc=1.
- LDI 0; NOT; HLT -> acc=0xFFFF, zflag=0. With ALU_LAT=0 -> NOT takes 3 cycles.
- Opcode 0xC at PC 2 -> halted=1, illegal=1, pc=3. start -> illegal clears, fetch resumes from pc=0.
- AW=4, program of NOPs -> pc wraps 15->0. A start pulse while busy has no effect.
